// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor decoding lives here so the top and any later users agree on
// what {N, half} means: output mode plus the counter wrap value P-1.
package clk_div_pkg;

  typedef enum logic [1:0] {
    MODE_EVEN,
    MODE_ODD,
    MODE_HALF
  } div_mode_e;

  localparam int unsigned DIV_MIN = 2;

  typedef struct packed {
    div_mode_e   mode;
    logic [31:0] wrap;
  } div_cfg_t;

  // Divisors below DIV_MIN cannot produce two distinct phases, so they are raised to it
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < DIV_MIN) ? DIV_MIN : n;
  endfunction

  function automatic div_mode_e div_mode(input logic n_lsb, input logic half);
    if (half) return MODE_HALF;
    return n_lsb ? MODE_ODD : MODE_EVEN;
  endfunction

  // Half mode counts 2N+1 input cycles per counter cycle (two output periods)
  function automatic logic [31:0] div_wrap(input logic [31:0] n, input logic half);
    return half ? (n << 1) : (n - 32'd1);
  endfunction

  function automatic div_cfg_t decode_div(input logic [31:0] n, input logic half);
    div_cfg_t cfg;
    cfg.mode = div_mode(n[0], half);
    cfg.wrap = div_wrap(n, half);
    return cfg;
  endfunction

endpackage

// File: rtl/clk_div_neg_stage.sv
// Falling-edge register of the divider. It is kept as its own instance so
// the half-cycle timing path and scan handling attach to a single cell.
// q_n is the complementary flop output used directly by the output gate.
module clk_div_neg_stage (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q_n
);

  logic q;

  // Capture on the falling edge; cleared asynchronously together with the posedge logic
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign q_n = ~q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: divide by N (50% duty, even or odd N)
// or by N+0.5. New ratios are shadowed and switched only at a counter wrap
// or when starting from the parked state, so clk_out never runts.
// clk_out = pos_q AND (inverted negedge block flop); pos_q changes only on
// rising edges and the block flop only on falling edges.
// Optional macro CLK_DIV_TICK_EN adds the 'tick' period-start output.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_INT  = 5,
  parameter int DEF_HALF = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_int,
  input  logic             div_half,
  input  logic             load,
  output logic             clk_out,
  output logic             upd_pend,
  output logic             running
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam int CW = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(clamp_div(32'(DEF_INT)));
  localparam logic DEF_H = (DEF_HALF != 0);

  logic [CW-1:0]    cnt, cnt_nxt, n_ext, half_ext;
  logic [CNT_W-1:0] act_int, act_int_nxt, sh_int, sh_int_nxt;
  logic             act_half, act_half_nxt, sh_half, sh_half_nxt;
  logic             pend_nxt, run_nxt, at_wrap, apply;
  logic             pos_q, pos_nxt, blk_q, blk_nxt, pass;
  div_cfg_t         cfg_nxt;

  // Next-state: period boundaries, shadow handover, and which flops gate clk_out
  // next cycle; blk is a look-ahead for the following half cycle so the first
  // half of cycle zero already matches the ratio that will be active then
  always_comb begin
    at_wrap = running && (32'(cnt) == div_wrap(32'(act_int), act_half));
    apply   = at_wrap || (!running && en);

    sh_int_nxt  = sh_int;
    sh_half_nxt = sh_half;
    if (load) begin
      sh_int_nxt  = CNT_W'(clamp_div(32'(div_int)));
      sh_half_nxt = div_half;
    end
    pend_nxt = load ? 1'b1 : (apply ? 1'b0 : upd_pend);

    act_int_nxt  = act_int;
    act_half_nxt = act_half;
    if (apply && upd_pend) begin
      act_int_nxt  = sh_int;
      act_half_nxt = sh_half;
    end

    run_nxt = running;
    cnt_nxt = cnt + 1'b1;
    if (!running || at_wrap) begin
      run_nxt = en;
      cnt_nxt = '0;
    end

    cfg_nxt  = decode_div(32'(act_int_nxt), act_half_nxt);
    n_ext    = {1'b0, act_int_nxt};
    half_ext = n_ext >> 1;

    pos_nxt = 1'b0;
    blk_nxt = (div_mode(pend_nxt ? sh_int_nxt[0] : act_int_nxt[0],
                        pend_nxt ? sh_half_nxt  : act_half_nxt) == MODE_ODD);
    if (run_nxt && (32'(cnt_nxt) != cfg_nxt.wrap)) begin
      case (cfg_nxt.mode)
        MODE_EVEN: begin
          pos_nxt = (cnt_nxt < half_ext);
          blk_nxt = 1'b0;
        end
        MODE_ODD: begin
          pos_nxt = (cnt_nxt <= half_ext);
          blk_nxt = (cnt_nxt > half_ext);
        end
        default: begin
          pos_nxt = (cnt_nxt == '0) || (cnt_nxt == n_ext);
          blk_nxt = (cnt_nxt < n_ext);
        end
      endcase
    end
  end

  // Posedge state: counter, run flag, active/shadow ratio and output operand flops
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      running  <= 1'b0;
      upd_pend <= 1'b0;
      act_int  <= DEF_N;
      act_half <= DEF_H;
      sh_int   <= DEF_N;
      sh_half  <= DEF_H;
      pos_q    <= 1'b0;
      blk_q    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      running  <= run_nxt;
      upd_pend <= pend_nxt;
      act_int  <= act_int_nxt;
      act_half <= act_half_nxt;
      sh_int   <= sh_int_nxt;
      sh_half  <= sh_half_nxt;
      pos_q    <= pos_nxt;
      blk_q    <= blk_nxt;
    end
  end

  clk_div_neg_stage u_neg_stage (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (blk_q),
    .q_n    (pass)
  );

  assign clk_out = pos_q & pass;

`ifdef CLK_DIV_TICK_EN
  // Period-start marker in the clk_in domain, high during counter cycle zero
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick <= 1'b0;
    else        tick <= run_nxt && (cnt_nxt == '0);
  end
`endif

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider producing divide-by-N (50% duty for even and odd N) and divide-by-N+0.5 from a single input clock. Ratio changes are shadowed and applied only at an output-period boundary, so the output never glitches or runts. It serves as the general clock-generation block for downstream peripherals, replacing fixed-ratio half-integer dividers.

## Interface
- CNT_W, 8: width of divisor field and internal counters; counters are CNT_W+1 bits.
- DEF_INT, 5: integer part of the divisor after reset.
- DEF_HALF, 1: half-step flag after reset; 1 means divide by DEF_INT+0.5.

- clk_in  in  1  source clock; all logic runs on its posedge, except one negedge stage.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable, sampled on posedge clk_in.
- div_int  in  CNT_W  requested integer divisor N.
- div_half  in  1  requested half-step; 1 selects N+0.5.
- load  in  1  one-cycle strobe; captures div_int/div_half into the shadow register.
- clk_out  out  1  divided clock.
- upd_pend  out  1  high from a load until the shadow value becomes active.
- running  out  1  high while an output period is in progress.

## Operation
- Effective N = max(div_int, 2). Values 0 and 1 are clamped to 2, both at load and at reset (DEF_INT).
- Counter c, posedge domain. Wrap value P-1 where P = N (integer mode) or P = 2N+1 (half mode). A "wrap edge" is the posedge at which c goes from P-1 to 0.
- Integer, even N: clk_out is high for c in [0, N/2-1] and low otherwise. Duty is exactly 50%.
- Integer, odd N: the posedge signal is high for c in [0, (N-1)/2]. A negedge-delayed copy is ANDed with it, giving N/2 input cycles high (50%).
- Half mode: clk_out has two pulses per counter cycle. Each pulse is high for half an input cycle:
  - pulse 1 runs from the posedge at c=0 to the following negedge;
  - pulse 2 runs from the negedge within c=N to the posedge at c=N+1.
  - Rising edges are therefore spaced exactly N+0.5 input cycles apart.
- clk_out is formed only by a single AND/OR of flop outputs. Both operand flops may never change on the same clk_in edge.
- Update handling:
  - load writes the shadow register and sets upd_pend.
  - At the next wrap edge, shadow → active and upd_pend clears.
  - If load coincides with a wrap edge, the new value applies at the following wrap edge.
  - Repeated loads before the update: the last one wins.
- Enable handling:
  - en falling: the current period completes, then c parks at 0, clk_out is held low and running=0.
  - en rising while parked: the period starts at the next posedge with clk_out rising.
  - A pending update applies at the parked-to-run transition.
- Reset values: clk_out=0, running=0, upd_pend=0, c=0, negedge stage=0, active ratio = {DEF_INT clamped, DEF_HALF}.
- Reset is asynchronous in both the posedge and negedge domains. Reset mid-period aborts the period immediately, and no pulse is emitted until after release.

## Timing
- The first clk_out rise occurs on the first posedge after rst_n release with en=1.
- Output period: N cycles (integer) or N+0.5 cycles (half mode, measured rise to rise).
- Ratio-change latency: at most one full output period plus one cycle from load.
- running rises with the first clk_out rise. It falls on the wrap edge that ends the last period after en drops.

## Configuration
- CLK_DIV_TICK_EN defined: adds output tick (1 bit). tick is a one-clk_in-cycle pulse, registered on the posedge, high in cycle c=0 of every counter cycle. It gives downstream logic a synchronous "period start" marker in the clk_in domain. Reset value 0.
- CLK_DIV_TICK_EN undefined: port and logic are absent.

## Structure
- Package clk_div_pkg holds:
  - mode enum MODE_EVEN, MODE_ODD, MODE_HALF;
  - constant DIV_MIN=2;
  - a function mapping {N, half} to mode and wrap value P-1.
- Sub-module clk_div_neg_stage: the negedge-clocked register with async reset. It is isolated so clock-edge constraints and DFT handling attach to one instance.

## Test plan
- 20 ns clk_in, reset defaults (5.5) → clk_out rising edges every 110 ns, each pulse 10 ns high, two pulses per 220 ns.
- load N=4, half=0 → after the next wrap edge, period 80 ns, high 40 ns; upd_pend high until that edge.
- load N=7, half=0 → period 140 ns, high exactly 70 ns (negedge stage exercised).
- load div_int=1 → behaves as N=2: period 40 ns, high 20 ns.
- en dropped mid-period at N=6 → the current 120 ns period completes, then clk_out is held low and running=0. en re-raised → rise on the next posedge.
- rst_n asserted mid-high phase → clk_out=0 immediately. After release, the first period is a full period with no runt. With CLK_DIV_TICK_EN, tick pulses once per counter cycle, aligned to c=0.
